ddr_app_responder: RTL and testbench



---
 rtl/ddr_app_pkg.sv | 31 +++
 rtl/ddr_app_ram.sv | 41 ++++
 rtl/ddr_app_responder.sv | 149 ++++++++++++++
 tb/tb_ddr_app_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_app_pkg.sv
// Shared definitions for the DDR3 application-interface responder.
//   - Command encodings seen on the cmd port.
//   - Controller state encoding.
//   - Counter width helpers.
package ddr_app_pkg;

  localparam logic [2:0] CMD_WRITE = 3'd0;
  localparam logic [2:0] CMD_READ  = 3'd1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_RD_WAIT,
    ST_READ
  } state_t;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int beat_width(input int burst_len);
    return cnt_width(burst_len);
  endfunction

  function automatic int lat_width(input int rd_latency);
    return cnt_width(rd_latency);
  endfunction

endpackage

// File: rtl/ddr_app_ram.sv
// Single-port backing RAM, DEPTH x DATA_WIDTH, per-byte write enable,
// synchronous 1-cycle read with read-first behaviour.
//   clk    sole clock
//   rst    synchronous active-high reset (output register only)
//   re     read enable; q updates only when set, otherwise holds
//   be     per-byte write enable, bit i covers wdata[8i+7:8i]
//   addr   word address
//   wdata  write word
//   q      registered read word
module ddr_app_ram #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      re,
  input  logic [DATA_WIDTH/8-1:0]   be,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH-1:0]     q
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; contents survive rst and only the
  // output register below is cleared.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (re) q <= mem[addr];
  end

endmodule

// File: rtl/ddr_app_responder.sv
// DDR3 user-side application interface responder backed by an internal RAM.
// Stands in for the memory-interface IP opposite the frame-buffer DMA.
//   clk, rst              clock, synchronous active-high reset
//   cmd/cmd_en/addr       command channel, accepted on cmd_en & cmd_ready
//   cmd_ready             high only in IDLE
//   wr_data*              write beats, accepted on wr_data_en & wr_data_rdy
//   rd_data*              read beats, RD_LATENCY cycles after accept
//   init_calib_complete   high once the calibration delay has elapsed
//   protocol_err          sticky violation flag, cleared by rst only
module ddr_app_responder
  import ddr_app_pkg::*;
#(
  parameter int ADDR_WIDTH   = 29,
  parameter int DATA_WIDTH   = 256,
  parameter int MEM_DEPTH    = 1024,
  parameter int BURST_LEN    = 1,
  parameter int CALIB_CYCLES = 16,
  parameter int RD_LATENCY   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    cmd_ready,
  input  logic [2:0]              cmd,
  input  logic                    cmd_en,
  input  logic [ADDR_WIDTH-1:0]   addr,
  output logic                    wr_data_rdy,
  input  logic                    wr_data_en,
  input  logic                    wr_data_end,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_data_mask,
  output logic                    rd_data_valid,
  output logic                    rd_data_end,
  output logic [DATA_WIDTH-1:0]   rd_data,
  output logic                    init_calib_complete,
  output logic                    protocol_err
);

  localparam int WORD_W = $clog2(MEM_DEPTH);
  localparam int BEAT_W = beat_width(BURST_LEN);
  localparam int LAT_W  = lat_width(RD_LATENCY);
  localparam int CAL_W  = cnt_width(CALIB_CYCLES);

  state_t              state, state_next;
  logic [WORD_W-1:0]   word, addr_word, ram_addr;
  logic [BEAT_W-1:0]   beat;
  logic [LAT_W-1:0]    lat;
  logic [CAL_W-1:0]    cal;
  logic                err;

  logic wr_cmd, rd_cmd, bad_cmd, beat_acc, beat_last, rd_last, ram_re;
  logic [DATA_WIDTH/8-1:0] ram_be;

  // Column address is in 32-bit units; a beat covers 8 columns. The cast
  // keeps the low WORD_W bits, i.e. the word index modulo MEM_DEPTH.
  assign addr_word = WORD_W'(addr >> 3);

  // Handshake decode and RAM control.
  always_comb begin
    wr_cmd    = (state == ST_IDLE) && cmd_en && (cmd == CMD_WRITE);
    rd_cmd    = (state == ST_IDLE) && cmd_en && (cmd == CMD_READ);
    bad_cmd   = (state == ST_IDLE) && cmd_en && !wr_cmd && !rd_cmd;
    beat_acc  = wr_data_en && (wr_cmd || (state == ST_WRITE));
    beat_last = (state == ST_IDLE) ? (BURST_LEN == 1) : (beat == BEAT_W'(BURST_LEN - 1));
    rd_last   = (beat == BEAT_W'(BURST_LEN - 1));
    // The RAM read is issued one cycle before each beat becomes valid.
    ram_re    = (rd_cmd && (RD_LATENCY == 1))
             || ((state == ST_RD_WAIT) && (lat == LAT_W'(RD_LATENCY - 2)))
             || ((state == ST_READ) && !rd_last);
    ram_be    = beat_acc ? ~wr_data_mask : '0;
    ram_addr  = (state == ST_IDLE) ? addr_word : word;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_next;
  end

  // NOTE: state_next is defaulted first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_INIT:    if (cal == CAL_W'(CALIB_CYCLES - 1)) state_next = ST_IDLE;
      ST_IDLE: begin
        if (wr_cmd && !(wr_data_en && (BURST_LEN == 1))) state_next = ST_WRITE;
        else if (rd_cmd) state_next = (RD_LATENCY == 1) ? ST_READ : ST_RD_WAIT;
      end
      ST_WRITE:   if (beat_acc && beat_last) state_next = ST_IDLE;
      ST_RD_WAIT: if (lat == LAT_W'(RD_LATENCY - 2)) state_next = ST_READ;
      ST_READ:    if (rd_last) state_next = ST_IDLE;
      default:    state_next = ST_INIT;
    endcase
  end

  always_comb begin
    cmd_ready           = (state == ST_IDLE);
    wr_data_rdy         = (state == ST_IDLE) || (state == ST_WRITE);
    rd_data_valid       = (state == ST_READ);
    rd_data_end         = (state == ST_READ) && rd_last;
    init_calib_complete = (state != ST_INIT);
    protocol_err        = err;
  end

  // Counters, burst pointer and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      cal  <= '0;
      lat  <= '0;
      beat <= '0;
      word <= '0;
      err  <= 1'b0;
    end else begin
      if (state == ST_INIT) cal <= cal + CAL_W'(1);

      // word always points at the next RAM location the burst will touch.
      if (ram_re || beat_acc)    word <= ram_addr + WORD_W'(1);
      else if (wr_cmd || rd_cmd) word <= addr_word;

      if (wr_cmd)                                   beat <= beat_acc ? BEAT_W'(1) : '0;
      else if (beat_acc || (state == ST_READ))      beat <= beat + BEAT_W'(1);
      else if (rd_cmd || (state == ST_RD_WAIT))     beat <= '0;

      if (rd_cmd)                  lat <= '0;
      else if (state == ST_RD_WAIT) lat <= lat + LAT_W'(1);

      if (((state == ST_INIT) && (cmd_en || wr_data_en))
          || bad_cmd
          || (wr_data_en && (state == ST_IDLE) && !wr_cmd)
          || (beat_acc && (wr_data_end != beat_last)))
        err <= 1'b1;
    end
  end

  ddr_app_ram #(
    .DEPTH      (MEM_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .re    (ram_re),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (wr_data),
    .q     (rd_data)
  );

endmodule

// File: tb/tb_ddr_app_responder.sv
// Bench for ddr_app_responder: one instance with single-beat bursts and one
// with four-beat bursts share the clock, reset and data buses; a selector
// routes the strobes and the observed outputs. Expected read data comes from
// a word-addressed associative-array memory model updated byte by byte.
module tb_ddr_app_responder;

  localparam int AW     = 29;
  localparam int DW     = 256;
  localparam int NB     = DW / 8;
  localparam int MEM_D  = 1024;
  localparam int RD_LAT = 4;
  localparam int CAL    = 16;

  logic clk = 1'b0;
  logic rst;
  logic [2:0]    cmd;
  logic          cmd_en, wr_data_en, wr_data_end;
  logic [AW-1:0] addr;
  logic [DW-1:0] wr_data;
  logic [NB-1:0] wr_data_mask;
  int            sel;

  logic cmd_en_1, cmd_en_4, wr_data_en_1, wr_data_en_4;
  logic cmd_ready_1, wr_data_rdy_1, rd_data_valid_1, rd_data_end_1, icc_1, err_1;
  logic cmd_ready_4, wr_data_rdy_4, rd_data_valid_4, rd_data_end_4, icc_4, err_4;
  logic [DW-1:0] rd_data_1, rd_data_4;

  logic          o_cmd_ready, o_wr_data_rdy, o_valid, o_end, o_err;
  logic [DW-1:0] o_rd_data;

  logic [DW-1:0] mem1 [int];
  logic [DW-1:0] mem4 [int];
  logic [DW-1:0] wd [8];
  logic [NB-1:0] wm [8];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign cmd_en_1     = cmd_en && (sel == 1);
  assign cmd_en_4     = cmd_en && (sel == 4);
  assign wr_data_en_1 = wr_data_en && (sel == 1);
  assign wr_data_en_4 = wr_data_en && (sel == 4);

  always_comb begin
    if (sel == 4) begin
      o_cmd_ready = cmd_ready_4; o_wr_data_rdy = wr_data_rdy_4; o_valid = rd_data_valid_4;
      o_end = rd_data_end_4; o_err = err_4; o_rd_data = rd_data_4;
    end else begin
      o_cmd_ready = cmd_ready_1; o_wr_data_rdy = wr_data_rdy_1; o_valid = rd_data_valid_1;
      o_end = rd_data_end_1; o_err = err_1; o_rd_data = rd_data_1;
    end
  end

  ddr_app_responder #(.BURST_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .cmd_ready(cmd_ready_1), .cmd(cmd), .cmd_en(cmd_en_1), .addr(addr),
    .wr_data_rdy(wr_data_rdy_1), .wr_data_en(wr_data_en_1), .wr_data_end(wr_data_end),
    .wr_data(wr_data), .wr_data_mask(wr_data_mask), .rd_data_valid(rd_data_valid_1),
    .rd_data_end(rd_data_end_1), .rd_data(rd_data_1), .init_calib_complete(icc_1),
    .protocol_err(err_1)
  );

  ddr_app_responder #(.BURST_LEN(4)) u_dut4 (
    .clk(clk), .rst(rst), .cmd_ready(cmd_ready_4), .cmd(cmd), .cmd_en(cmd_en_4), .addr(addr),
    .wr_data_rdy(wr_data_rdy_4), .wr_data_en(wr_data_en_4), .wr_data_end(wr_data_end),
    .wr_data(wr_data), .wr_data_mask(wr_data_mask), .rd_data_valid(rd_data_valid_4),
    .rd_data_end(rd_data_end_4), .rd_data(rd_data_4), .init_calib_complete(icc_4),
    .protocol_err(err_4)
  );

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_d, input logic [DW-1:0] new_d,
                                          input logic [NB-1:0] m);
    logic [DW-1:0] r;
    for (int i = 0; i < NB; i++) r[8*i +: 8] = m[i] ? old_d[8*i +: 8] : new_d[8*i +: 8];
    return r;
  endfunction

  function automatic bit m_has(input int k);
    return (sel == 4) ? (mem4.exists(k) != 0) : (mem1.exists(k) != 0);
  endfunction

  function automatic logic [DW-1:0] m_get(input int k);
    return (sel == 4) ? mem4[k] : mem1[k];
  endfunction

  task automatic m_put(input int k, input logic [DW-1:0] v);
    if (sel == 4) mem4[k] = v;
    else          mem1[k] = v;
  endtask

  function automatic int cur_bl();
    return (sel == 4) ? 4 : 1;
  endfunction

  // ---------------- bus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cmd_en = 1'b0; wr_data_en = 1'b0; wr_data_end = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a);
    int bl = cur_bl();
    int w  = int'(a >> 3) % MEM_D;
    n_checks++;
    if (o_cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL wr_cmd_ready: got %b expected 1", o_cmd_ready);
    end
    for (int b = 0; b < bl; b++) begin
      int k = (w + b) % MEM_D;
      if (b > 0) begin
        n_checks++;
        if (o_cmd_ready !== 1'b0 || o_wr_data_rdy !== 1'b1) begin
          n_fail++; $display("FAIL write_state_ready: got cmd_ready=%b wr_data_rdy=%b expected 0/1",
                             o_cmd_ready, o_wr_data_rdy);
        end
      end
      cmd_en = (b == 0); cmd = 3'd0; addr = a;
      wr_data_en = 1'b1; wr_data = wd[b]; wr_data_mask = wm[b]; wr_data_end = (b == bl - 1);
      m_put(k, merge(m_has(k) ? m_get(k) : '0, wd[b], wm[b]));
      tick();
    end
    idle_bus();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    int bl = cur_bl();
    int w  = int'(a >> 3) % MEM_D;
    n_checks++;
    if (o_cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL rd_cmd_ready: got %b expected 1", o_cmd_ready);
    end
    cmd_en = 1'b1; cmd = 3'd1; addr = a;
    tick();
    idle_bus();
    for (int k = 1; k <= RD_LAT + bl; k++) begin
      bit ev = (k >= RD_LAT) && (k < RD_LAT + bl);
      n_checks++;
      if (o_valid !== ev) begin
        n_fail++; $display("FAIL rd_valid cyc%0d word %0d: got %b expected %b", k, w, o_valid, ev);
      end
      if (ev) begin
        int b   = k - RD_LAT;
        int key = (w + b) % MEM_D;
        n_checks++;
        if (o_end !== (b == bl - 1)) begin
          n_fail++; $display("FAIL rd_end beat%0d: got %b expected %b", b, o_end, (b == bl - 1));
        end
        if (m_has(key)) begin
          n_checks++;
          if (o_rd_data !== m_get(key)) begin
            n_fail++; $display("FAIL rd_data word %0d: got %h expected %h", key, o_rd_data, m_get(key));
          end
        end
      end else if (k == RD_LAT + bl) begin
        int key = (w + bl - 1) % MEM_D;
        n_checks++;
        if (o_cmd_ready !== 1'b1) begin
          n_fail++; $display("FAIL rd_return_idle: got cmd_ready=%b expected 1", o_cmd_ready);
        end
        if (m_has(key)) begin
          n_checks++;
          if (o_rd_data !== m_get(key)) begin
            n_fail++; $display("FAIL rd_data_hold: got %h expected %h", o_rd_data, m_get(key));
          end
        end
      end else begin
        n_checks++;
        if (o_cmd_ready !== 1'b0) begin
          n_fail++; $display("FAIL rd_busy_ready cyc%0d: got %b expected 0", k, o_cmd_ready);
        end
      end
      tick();
    end
  endtask

  task automatic wait_calib();
    for (int k = 1; k <= CAL; k++) begin
      tick();
      n_checks++;
      if (icc_1 !== (k >= CAL) || icc_4 !== (k >= CAL)) begin
        n_fail++; $display("FAIL calib cyc%0d: got %b/%b expected %b", k, icc_1, icc_4, (k >= CAL));
      end
      n_checks++;
      if (rd_data_valid_1 !== 1'b0 || rd_data_valid_4 !== 1'b0) begin
        n_fail++; $display("FAIL calib_valid cyc%0d: got %b/%b expected 0", k,
                           rd_data_valid_1, rd_data_valid_4);
      end
    end
    n_checks++;
    if (cmd_ready_1 !== 1'b1 || cmd_ready_4 !== 1'b1) begin
      n_fail++; $display("FAIL calib_ready: got %b/%b expected 1", cmd_ready_1, cmd_ready_4);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    n_checks++;
    if ({cmd_ready_1, wr_data_rdy_1, rd_data_valid_1, rd_data_end_1, icc_1, err_1} !== 6'b0
        || rd_data_1 !== '0) begin
      n_fail++; $display("FAIL %s dut1: got flags=%b rd_data=%h expected 0", tag,
        {cmd_ready_1, wr_data_rdy_1, rd_data_valid_1, rd_data_end_1, icc_1, err_1}, rd_data_1);
    end
    n_checks++;
    if ({cmd_ready_4, wr_data_rdy_4, rd_data_valid_4, rd_data_end_4, icc_4, err_4} !== 6'b0
        || rd_data_4 !== '0) begin
      n_fail++; $display("FAIL %s dut4: got flags=%b rd_data=%h expected 0", tag,
        {cmd_ready_4, wr_data_rdy_4, rd_data_valid_4, rd_data_end_4, icc_4, err_4}, rd_data_4);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; sel = 1; idle_bus(); cmd = 3'd0; addr = '0; wr_data = '0; wr_data_mask = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_outputs_zero("reset");
    wait_calib();
  endtask

  task automatic test_write_read();
    sel = 1;
    wd[0] = {NB{8'hA5}}; wm[0] = '0;
    do_write(29'h10);
    do_read(29'h10);
    n_checks++;
    if (o_err !== 1'b0) begin
      n_fail++; $display("FAIL wr_rd_err: got %b expected 0", o_err);
    end
  endtask

  task automatic test_mask();
    sel = 1;
    wd[0] = {NB{8'hFF}}; wm[0] = 32'hFFFF_FFFE;
    do_write(29'h10);
    do_read(29'h10);
    n_checks++;
    if (o_rd_data !== {{31{8'hA5}}, 8'hFF}) begin
      n_fail++; $display("FAIL mask_merge: got %h expected %h", o_rd_data, {{31{8'hA5}}, 8'hFF});
    end
  endtask

  task automatic test_burst_wrap();
    sel = 4;
    for (int b = 0; b < 4; b++) begin
      wd[b] = {8{$urandom}}; wm[b] = '0;
    end
    do_write(29'(2 * 8));
    for (int b = 0; b < 4; b++) begin
      wd[b] = DW'(b + 1); wm[b] = '0;
    end
    do_write(29'(1022 * 8));
    do_read(29'(1022 * 8));
    do_read(29'h0);
  endtask

  task automatic test_reset_mid();
    sel = 1;
    cmd_en = 1'b1; cmd = 3'd1; addr = 29'h10;
    tick();
    idle_bus();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_outputs_zero("reset_mid");
    wait_calib();
    do_read(29'h10);
  endtask

  task automatic test_protocol();
    sel = 1;
    n_checks++;
    if (o_err !== 1'b0) begin
      n_fail++; $display("FAIL perr_clean1: got %b expected 0", o_err);
    end
    cmd_en = 1'b1; cmd = 3'd5; addr = 29'h10; wr_data = '0; wr_data_mask = '0;
    tick();
    idle_bus();
    n_checks++;
    if (o_err !== 1'b1 || o_cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL perr_bad_cmd: got err=%b ready=%b expected 1/1", o_err, o_cmd_ready);
    end
    do_read(29'h10);

    sel = 4;
    #1;
    n_checks++;
    if (o_err !== 1'b0) begin
      n_fail++; $display("FAIL perr_clean4: got %b expected 0", o_err);
    end
    wr_data_en = 1'b1; wr_data_end = 1'b1; wr_data = '0; addr = 29'h10;
    tick();
    idle_bus();
    n_checks++;
    if (o_err !== 1'b1) begin
      n_fail++; $display("FAIL perr_stray_beat: got %b expected 1", o_err);
    end
    do_read(29'h10);
    repeat (5) tick();
    n_checks++;
    if (err_1 !== 1'b1 || err_4 !== 1'b1) begin
      n_fail++; $display("FAIL perr_sticky: got %b/%b expected 1/1", err_1, err_4);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 2; s++) begin
      sel = (s == 0) ? 1 : 4;
      #1;
      for (int it = 0; it < 20; it++) begin
        int bl = cur_bl();
        int w  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MEM_D - 4, MEM_D - 1))
                                              : int'($urandom_range(0, MEM_D - 1));
        bit known = 1'b1;
        logic [AW-1:0] a, a2;
        for (int b = 0; b < bl; b++) if (!m_has((w + b) % MEM_D)) known = 1'b0;
        for (int b = 0; b < bl; b++) begin
          wd[b] = {8{$urandom}};
          wm[b] = known ? NB'($urandom) : '0;
        end
        a  = AW'($urandom); a[12:3]  = 10'(w);
        a2 = AW'($urandom); a2[12:3] = 10'(w);
        do_write(a);
        do_read(a2);
      end
    end
  endtask

  task automatic test_err_clear();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (err_1 !== 1'b0 || err_4 !== 1'b0) begin
      n_fail++; $display("FAIL perr_clear: got %b/%b expected 0/0", err_1, err_4);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_burst_wrap();
    test_reset_mid();
    test_protocol();
    test_random();
    test_err_clear();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
